mul_share_arbiter: RTL and testbench

- Shares one multiplier8 instance (start/a/b in, p/ready out) between N requesters.
- Arbitration is round-robin. The block owns the multiplier's start pulse and operand buses, waits for the multiplier's ready, and returns the 16-bit product tagged with the requester id.
- Sits between client blocks and a single multiplier8. It replaces per-client multipliers.

---
 rtl/mul_share_arbiter.sv | 142 ++++++++++++++
 tb/tb_mul_share_arbiter.sv | 464 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter that shares one multiplier8 between N requesters.
// All outputs are registered. A multiplier that never signals ready produces an error response.
module mul_share_arbiter #(
    parameter int N       = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     req_valid,
    input  logic [8*N-1:0]   req_a,
    input  logic [8*N-1:0]   req_b,
    output logic [N-1:0]     req_ready,
    output logic             resp_valid,
    output logic [IDW-1:0]   resp_id,
    output logic [15:0]      resp_p,
    output logic             resp_err,
    output logic             mul_start,
    output logic [7:0]       mul_a,
    output logic [7:0]       mul_b,
    input  logic [15:0]      mul_p,
    input  logic             mul_ready
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, START, HOLD, WAIT, DONE} state_t;

    state_t         state, next_state;
    logic [IDW-1:0] rr, owner;
    logic [CW-1:0]  wait_cnt;
    logic           wait_expired;

    logic           found_hi, found_lo, pick_found;
    logic [IDW-1:0] hi_idx, lo_idx, pick_idx;
    logic [N-1:0]   pick_onehot;
    logic [7:0]     pick_a, pick_b;

    // Two scans: the first valid index at or above rr wins, else the lowest valid index (wrap).
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = 0; i < N; i++) begin
            if (!found_hi && req_valid[i] && (i >= int'(rr))) begin
                found_hi = 1'b1;
                hi_idx   = IDW'(i);
            end
            if (!found_lo && req_valid[i]) begin
                found_lo = 1'b1;
                lo_idx   = IDW'(i);
            end
        end
        pick_found = found_lo;
        pick_idx   = found_hi ? hi_idx : lo_idx;
    end

    always_comb begin
        pick_onehot = '0;
        pick_a      = '0;
        pick_b      = '0;
        for (int i = 0; i < N; i++) begin
            if (IDW'(i) == pick_idx) begin
                pick_onehot[i] = 1'b1;
                pick_a         = req_a[8*i +: 8];
                pick_b         = req_b[8*i +: 8];
            end
        end
    end

    assign wait_expired = (wait_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // HOLD exists so that a ready left over from the previous operation is never taken as completion.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (pick_found) next_state = START;
            START:   next_state = HOLD;
            HOLD:    next_state = WAIT;
            WAIT:    if (mul_ready || wait_expired) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_ready  <= '0;
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_p     <= '0;
            resp_err   <= 1'b0;
            mul_start  <= 1'b0;
            mul_a      <= '0;
            mul_b      <= '0;
            owner      <= '0;
            rr         <= '0;
            wait_cnt   <= '0;
        end else begin
            req_ready  <= '0;
            resp_valid <= 1'b0;
            mul_start  <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        owner     <= pick_idx;
                        mul_a     <= pick_a;
                        mul_b     <= pick_b;
                        mul_start <= 1'b1;
                        req_ready <= pick_onehot;
                    end
                end
                HOLD: wait_cnt <= '0;
                WAIT: begin
                    if (mul_ready) begin
                        resp_p     <= mul_p;
                        resp_err   <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_id    <= owner;
                    end else if (wait_expired) begin
                        resp_p     <= '0;
                        resp_err   <= 1'b1;
                        resp_valid <= 1'b1;
                        resp_id    <= owner;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                DONE: rr <= (owner == IDW'(N - 1)) ? '0 : owner + 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_share_arbiter.sv
// Self-checking bench for mul_share_arbiter: a behavioural multiplier8 with variable latency,
// a response/grant monitor, and a plain round-robin ordering model.
module tb_mul_share_arbiter;
    localparam int N       = 4;
    localparam int IDW     = 2;
    localparam int TIMEOUT = 32;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [8*N-1:0] req_a = '0;
    logic [8*N-1:0] req_b = '0;
    logic [N-1:0]   req_ready;
    logic           resp_valid;
    logic [IDW-1:0] resp_id;
    logic [15:0]    resp_p;
    logic           resp_err;
    logic           mul_start;
    logic [7:0]     mul_a, mul_b;
    logic [15:0]    mul_p;
    logic           mul_ready;

    int checks = 0;
    int failures = 0;
    int exp_rr = 0;
    bit mul_stuck = 1'b0;

    typedef struct {
        int id;
        int p;
        bit err;
        int cyc;
    } rsp_t;

    typedef struct {
        int idx;
        int cyc;
    } acc_t;

    rsp_t rsp_q[$];
    acc_t acc_q[$];
    int   cyc = 0;
    int   starts = 0;
    int   overlap = 0;
    int   bad_onehot = 0;
    int   misalign = 0;
    int   long_pulse = 0;
    bit   busy = 1'b0;
    bit   prev_rv = 1'b0;
    bit   prev_ms = 1'b0;

    mul_share_arbiter #(.N(N), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_id    (resp_id),
        .resp_p     (resp_p),
        .resp_err   (resp_err),
        .mul_start  (mul_start),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_p      (mul_p),
        .mul_ready  (mul_ready)
    );

    always #5 clk = ~clk;

    // multiplier8 model: ready drops one cycle late, so a stale ready is visible during HOLD
    logic arm;
    int   mcnt;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mul_ready <= 1'b1;
            mul_p     <= '0;
            arm       <= 1'b0;
            mcnt      <= 0;
        end else if (mul_start) begin
            arm <= 1'b1;
        end else if (arm) begin
            arm       <= 1'b0;
            mul_ready <= 1'b0;
            mcnt      <= $urandom_range(1, 5);
        end else if (!mul_ready && !mul_stuck) begin
            if (mcnt <= 1) begin
                mul_ready <= 1'b1;
                mul_p     <= 16'(mul_a) * 16'(mul_b);
            end else begin
                mcnt <= mcnt - 1;
            end
        end
    end

    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            busy    = 1'b0;
            prev_rv = 1'b0;
            prev_ms = 1'b0;
        end else begin
            if (mul_start) begin
                starts++;
                if (busy) overlap++;
                busy = 1'b1;
            end
            if (resp_valid) begin
                rsp_q.push_back('{id: int'(resp_id), p: int'(resp_p), err: resp_err, cyc: cyc});
                busy = 1'b0;
            end
            if (req_ready != '0) begin
                int idx;
                idx = 0;
                if ($countones(req_ready) != 1) bad_onehot++;
                for (int i = 0; i < N; i++) if (req_ready[i]) idx = i;
                acc_q.push_back('{idx: idx, cyc: cyc});
            end
            if (mul_start != (req_ready != '0)) misalign++;
            if ((resp_valid && prev_rv) || (mul_start && prev_ms)) long_pulse++;
            prev_rv = resp_valid;
            prev_ms = mul_start;
        end
    end

    function automatic int next_grant(input int rr, input logic [N-1:0] pend);
        for (int k = 0; k < N; k++) begin
            if (pend[(rr + k) % N]) return (rr + k) % N;
        end
        return -1;
    endfunction

    // Raise the masked requests, drop each one as its grant is seen, wait for n responses.
    task automatic serve(input logic [N-1:0] mask, input int n, output bit ok);
        int base;
        base = rsp_q.size();
        ok = 1'b0;
        @(negedge clk);
        #1 req_valid = mask;
        for (int c = 0; c < 20 * n + 40; c++) begin
            @(negedge clk);
            #1 req_valid = req_valid & ~req_ready;
            if (rsp_q.size() >= base + n) begin
                ok = 1'b1;
                break;
            end
        end
        req_valid = '0;
    endtask

    task automatic test_reset();
        logic [40:0] outs;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        outs = {req_ready, resp_valid, resp_id, resp_p, resp_err, mul_start, mul_a, mul_b};
        checks++;
        if (outs !== '0) begin
            failures++;
            $display("[TB] FAIL reset_outputs got=%h want=0", outs);
        end
        reset = 1'b0;
        exp_rr = 0;
    endtask

    task automatic test_all_valid();
        logic [N-1:0] pend;
        int base, st0, rr, g;
        bit ok;
        for (int i = 0; i < N; i++) begin
            req_a[8*i +: 8] = 8'(i + 1);
            req_b[8*i +: 8] = 8'd255;
        end
        base = rsp_q.size();
        st0 = starts;
        serve(4'hF, 4, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("[TB] FAIL all_valid_timeout got=%0d responses want=4", rsp_q.size() - base);
        end
        pend = 4'hF;
        rr = exp_rr;
        for (int k = 0; k < N; k++) begin
            g = next_grant(rr, pend);
            pend = pend & ~(4'(1) << g);
            rr = (g + 1) % N;
            checks++;
            if (base + k >= rsp_q.size()) begin
                failures++;
                $display("[TB] FAIL all_valid_missing k=%0d", k);
            end else if (rsp_q[base+k].id != g || rsp_q[base+k].p != (g + 1) * 255 || rsp_q[base+k].err) begin
                failures++;
                $display("[TB] FAIL all_valid_rsp k=%0d got id=%0d p=%0d err=%0d want id=%0d p=%0d err=0",
                         k, rsp_q[base+k].id, rsp_q[base+k].p, rsp_q[base+k].err, g, (g + 1) * 255);
            end
        end
        exp_rr = rr;
        checks++;
        if (starts - st0 != 4) begin
            failures++;
            $display("[TB] FAIL all_valid_starts got=%0d want=4", starts - st0);
        end
    endtask

    task automatic test_single();
        int base, abase, st0;
        bit ok;
        req_a[16 +: 8] = 8'd13;
        req_b[16 +: 8] = 8'd11;
        base = rsp_q.size();
        abase = acc_q.size();
        st0 = starts;
        serve(4'b0100, 1, ok);
        checks++;
        if (!ok || rsp_q[base].id != 2 || rsp_q[base].p != 143 || rsp_q[base].err) begin
            failures++;
            $display("[TB] FAIL single_rsp got ok=%0d id=%0d p=%0d err=%0d want id=2 p=143 err=0",
                     ok, rsp_q[base].id, rsp_q[base].p, rsp_q[base].err);
        end
        checks++;
        if (acc_q.size() - abase != 1 || acc_q[abase].idx != 2 || starts - st0 != 1) begin
            failures++;
            $display("[TB] FAIL single_grant got accepts=%0d idx=%0d starts=%0d want 1/2/1",
                     acc_q.size() - abase, acc_q[abase].idx, starts - st0);
        end
        exp_rr = 3;
    endtask

    task automatic test_rr_wrap();
        int base;
        bit ok;
        req_a[24 +: 8] = 8'd3;
        req_b[24 +: 8] = 8'd5;
        req_a[0 +: 8]  = 8'd7;
        req_b[0 +: 8]  = 8'd9;
        serve(4'b1000, 1, ok);
        exp_rr = 0;
        base = rsp_q.size();
        serve(4'b1001, 2, ok);
        checks++;
        if (!ok || rsp_q[base].id != 0 || rsp_q[base].p != 63) begin
            failures++;
            $display("[TB] FAIL rr_wrap_first got id=%0d p=%0d want id=0 p=63", rsp_q[base].id, rsp_q[base].p);
        end
        checks++;
        if (!ok || rsp_q[base+1].id != 3 || rsp_q[base+1].p != 15) begin
            failures++;
            $display("[TB] FAIL rr_wrap_second got id=%0d p=%0d want id=3 p=15", rsp_q[base+1].id, rsp_q[base+1].p);
        end
        exp_rr = 0;
    endtask

    task automatic test_boundary();
        int base, r;
        bit ok;
        r = $urandom_range(0, N - 1);
        req_a[8*r +: 8] = 8'd255;
        req_b[8*r +: 8] = 8'd255;
        base = rsp_q.size();
        serve(4'(1) << r, 1, ok);
        checks++;
        if (!ok || rsp_q[base].id != r || rsp_q[base].p != 65025 || rsp_q[base].err) begin
            failures++;
            $display("[TB] FAIL boundary_max got id=%0d p=%0d err=%0d want id=%0d p=65025 err=0",
                     rsp_q[base].id, rsp_q[base].p, rsp_q[base].err, r);
        end
        r = $urandom_range(0, N - 1);
        req_a[8*r +: 8] = 8'd0;
        req_b[8*r +: 8] = 8'd200;
        base = rsp_q.size();
        serve(4'(1) << r, 1, ok);
        checks++;
        if (!ok || rsp_q[base].id != r || rsp_q[base].p != 0 || rsp_q[base].err) begin
            failures++;
            $display("[TB] FAIL boundary_zero got id=%0d p=%0d err=%0d want id=%0d p=0 err=0",
                     rsp_q[base].id, rsp_q[base].p, rsp_q[base].err, r);
        end
        exp_rr = (r + 1) % N;
    endtask

    task automatic test_random();
        for (int b = 0; b < 8; b++) begin
            logic [N-1:0] mask, pend;
            logic [7:0]   av[N], bv[N];
            int           base, rr, g;
            bit           ok;
            mask = 4'($urandom_range(1, 15));
            for (int i = 0; i < N; i++) begin
                av[i] = 8'($urandom);
                bv[i] = 8'($urandom);
                req_a[8*i +: 8] = av[i];
                req_b[8*i +: 8] = bv[i];
            end
            base = rsp_q.size();
            serve(mask, $countones(mask), ok);
            checks++;
            if (!ok) begin
                failures++;
                $display("[TB] FAIL random_timeout batch=%0d got=%0d want=%0d", b, rsp_q.size() - base, $countones(mask));
            end
            pend = mask;
            rr = exp_rr;
            for (int k = 0; k < N; k++) begin
                if (pend != '0) begin
                    g = next_grant(rr, pend);
                    pend = pend & ~(4'(1) << g);
                    rr = (g + 1) % N;
                    checks++;
                    if (base + k >= rsp_q.size()) begin
                        failures++;
                        $display("[TB] FAIL random_missing batch=%0d k=%0d", b, k);
                    end else if (rsp_q[base+k].id != g || rsp_q[base+k].p != int'(av[g]) * int'(bv[g]) || rsp_q[base+k].err) begin
                        failures++;
                        $display("[TB] FAIL random_rsp batch=%0d k=%0d got id=%0d p=%0d err=%0d want id=%0d p=%0d err=0",
                                 b, k, rsp_q[base+k].id, rsp_q[base+k].p, rsp_q[base+k].err, g, int'(av[g]) * int'(bv[g]));
                    end
                end
            end
            exp_rr = rr;
        end
    endtask

    task automatic test_timeout();
        int base, abase, r, lat;
        logic [7:0] a, b;
        bit ok;
        mul_stuck = 1'b1;
        r = $urandom_range(0, N - 1);
        req_a[8*r +: 8] = 8'd21;
        req_b[8*r +: 8] = 8'd17;
        base = rsp_q.size();
        abase = acc_q.size();
        serve(4'(1) << r, 1, ok);
        checks++;
        if (!ok || rsp_q[base].id != r || rsp_q[base].p != 0 || !rsp_q[base].err) begin
            failures++;
            $display("[TB] FAIL timeout_rsp got ok=%0d id=%0d p=%0d err=%0d want id=%0d p=0 err=1",
                     ok, rsp_q[base].id, rsp_q[base].p, rsp_q[base].err, r);
        end
        lat = rsp_q[base].cyc - acc_q[abase].cyc;
        checks++;
        if (lat < TIMEOUT + 1 || lat > TIMEOUT + 3) begin
            failures++;
            $display("[TB] FAIL timeout_latency got=%0d want %0d..%0d", lat, TIMEOUT + 1, TIMEOUT + 3);
        end
        exp_rr = (r + 1) % N;
        mul_stuck = 1'b0;
        repeat (10) @(negedge clk);
        r = $urandom_range(0, N - 1);
        a = 8'($urandom);
        b = 8'($urandom);
        req_a[8*r +: 8] = a;
        req_b[8*r +: 8] = b;
        base = rsp_q.size();
        serve(4'(1) << r, 1, ok);
        checks++;
        if (!ok || rsp_q[base].id != r || rsp_q[base].p != int'(a) * int'(b) || rsp_q[base].err) begin
            failures++;
            $display("[TB] FAIL after_timeout_rsp got id=%0d p=%0d err=%0d want id=%0d p=%0d err=0",
                     rsp_q[base].id, rsp_q[base].p, rsp_q[base].err, r, int'(a) * int'(b));
        end
        exp_rr = (r + 1) % N;
    endtask

    task automatic test_reset_mid_wait();
        int base, abase;
        logic [40:0] outs;
        logic [7:0] a, b;
        bit ok;
        mul_stuck = 1'b1;
        req_a[24 +: 8] = 8'd77;
        req_b[24 +: 8] = 8'd99;
        base = rsp_q.size();
        abase = acc_q.size();
        @(negedge clk);
        #1 req_valid = 4'b1000;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            if (acc_q.size() > abase) break;
        end
        req_valid = '0;
        checks++;
        if (acc_q.size() == abase) begin
            failures++;
            $display("[TB] FAIL mid_wait_accept got=0 want=1 grant");
        end
        repeat (6) @(negedge clk);
        checks++;
        if (mul_a !== 8'd77 || mul_b !== 8'd99) begin
            failures++;
            $display("[TB] FAIL operand_hold got a=%0d b=%0d want a=77 b=99", mul_a, mul_b);
        end
        #3 reset = 1'b1;
        #1;
        outs = {req_ready, resp_valid, resp_id, resp_p, resp_err, mul_start, mul_a, mul_b};
        checks++;
        if (outs !== '0) begin
            failures++;
            $display("[TB] FAIL async_reset_outputs got=%h want=0", outs);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        mul_stuck = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (rsp_q.size() != base) begin
            failures++;
            $display("[TB] FAIL reset_discard got=%0d responses want=0", rsp_q.size() - base);
        end
        exp_rr = 0;
        a = 8'($urandom);
        b = 8'($urandom);
        req_a[8 +: 8] = a;
        req_b[8 +: 8] = b;
        base = rsp_q.size();
        serve(4'b0010, 1, ok);
        checks++;
        if (!ok || rsp_q[base].id != 1 || rsp_q[base].p != int'(a) * int'(b) || rsp_q[base].err) begin
            failures++;
            $display("[TB] FAIL post_reset_rsp got id=%0d p=%0d err=%0d want id=1 p=%0d err=0",
                     rsp_q[base].id, rsp_q[base].p, rsp_q[base].err, int'(a) * int'(b));
        end
        exp_rr = 2;
    endtask

    task automatic test_protocol();
        checks++;
        if (overlap != 0) begin
            failures++;
            $display("[TB] FAIL start_overlap got=%0d want=0", overlap);
        end
        checks++;
        if (bad_onehot != 0 || misalign != 0) begin
            failures++;
            $display("[TB] FAIL grant_shape got onehot_err=%0d misalign=%0d want 0/0", bad_onehot, misalign);
        end
        checks++;
        if (long_pulse != 0) begin
            failures++;
            $display("[TB] FAIL pulse_width got=%0d long pulses want=0", long_pulse);
        end
        checks++;
        if (starts != acc_q.size()) begin
            failures++;
            $display("[TB] FAIL start_count got=%0d want=%0d", starts, acc_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_all_valid();
        test_single();
        test_rr_wrap();
        test_boundary();
        test_random();
        test_timeout();
        test_reset_mid_wait();
        test_protocol();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
